// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared LC-3b fetch types: opcode, fetch FSM states, IF/ID record
package fetch_stage_pkg;

  typedef logic [3:0]  lc3b_opcode;
  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic     valid;
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_ifid_t;

  function automatic lc3b_word pc_next(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-cache read bus between fetch (master) and I-cache (slave)
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic     imem_read;
  lc3b_word imem_address;
  logic     imem_resp;
  lc3b_word imem_rdata;

  modport master (output imem_read, output imem_address, input imem_resp, input imem_rdata);
  modport slave  (input imem_read, input imem_address, output imem_resp, output imem_rdata);

endinterface

// File: rtl/fetch_stage_buffer.sv
// rtl/fetch_stage_buffer.sv - IF/ID register plus one-entry hold buffer forming an in-order skid pair
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  lc3b_word   in_pc,
  input  lc3b_word   in_ir,
  input  logic       out_ready,
  output lc3b_ifid_t ifid,
  output logic       hold_valid
);

  lc3b_word hold_pc;
  lc3b_word hold_ir;
  logic     transfer;

  assign transfer = ifid.valid && out_ready;

  // The hold entry is always older than any incoming word, so it drains first.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid       <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_ir    <= '0;
    end else if (flush) begin
      ifid.valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (hold_valid && transfer) begin
      ifid       <= '{valid: 1'b1, pc: hold_pc, ir: hold_ir};
      hold_valid <= 1'b0;
    end else if (in_valid) begin
      if (!ifid.valid || transfer) begin
        ifid <= '{valid: 1'b1, pc: in_pc, ir: in_ir};
      end else begin
        hold_pc    <= in_pc;
        hold_ir    <= in_ir;
        hold_valid <= 1'b1;
      end
    end else if (transfer) begin
      ifid.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b instruction fetch: PC, I-cache handshake, redirect handling, IF/ID output
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter lc3b_word PC_RESET = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 redirect,
  input  lc3b_word             redirect_pc,
  input  logic                 id_ready,
  output logic                 ifid_valid,
  output lc3b_word             ifid_pc,
  output lc3b_word             ifid_ir,
  output lc3b_opcode           ifid_opcode,
  output logic                 ifid_bit_11,
  output logic                 ifid_bit_5,
  output logic                 ifid_bit_4
);

  fetch_state_t state;
  lc3b_word     pc;
  lc3b_word     pc_plus2;
  lc3b_word     redirect_target;
  logic         hold_valid;
  logic         resp_seen;
  logic         accept;
  lc3b_ifid_t   ifid;

  // While discarding, the old request must stay up until the cache answers it.
  assign imem.imem_read    = !reset && ((state == S_DISCARD) || !hold_valid);
  assign imem.imem_address = pc;

  assign pc_plus2  = pc_next(pc);
  assign resp_seen = imem.imem_read && imem.imem_resp;
  assign accept    = (state == S_FETCH) && resp_seen && !redirect;

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .in_valid   (accept),
    .in_pc      (pc_plus2),
    .in_ir      (imem.imem_rdata),
    .out_ready  (id_ready),
    .ifid       (ifid),
    .hold_valid (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_FETCH;
      pc              <= PC_RESET;
      redirect_target <= '0;
    end else if (redirect) begin
      if (imem.imem_read && !imem.imem_resp) begin
        state           <= S_DISCARD;
        redirect_target <= redirect_pc;
      end else begin
        state <= S_FETCH;
        pc    <= redirect_pc;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (resp_seen) begin
            pc <= pc_plus2;
          end
        end
        S_DISCARD: begin
          if (resp_seen) begin
            pc    <= redirect_target;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign ifid_valid  = ifid.valid;
  assign ifid_pc     = ifid.pc;
  assign ifid_ir     = ifid.ir;
  assign ifid_opcode = ifid.ir[15:12];
  assign ifid_bit_11 = ifid.ir[11];
  assign ifid_bit_5  = ifid.ir[5];
  assign ifid_bit_4  = ifid.ir[4];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a variable-latency I-cache model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [15:0] PC_RESET = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_ready = 1'b0;
  logic        ifid_valid;
  logic [15:0] ifid_pc, ifid_ir;
  lc3b_opcode  ifid_opcode;
  logic        ifid_bit_11, ifid_bit_5, ifid_bit_4;

  logic        w_redirect = 1'b0;
  logic [15:0] w_redirect_pc = 16'h0000;
  logic        w_id_ready = 1'b1;
  logic        w_ifid_valid;
  logic [15:0] w_ifid_pc, w_ifid_ir;
  lc3b_opcode  w_ifid_opcode;
  logic        w_bit_11, w_bit_5, w_bit_4;

  fetch_stage_if imem_bus ();
  fetch_stage_if wrap_bus ();

  fetch_stage #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .reset(reset), .imem(imem_bus), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir),
    .ifid_opcode(ifid_opcode), .ifid_bit_11(ifid_bit_11), .ifid_bit_5(ifid_bit_5), .ifid_bit_4(ifid_bit_4)
  );

  fetch_stage #(.PC_RESET(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .imem(wrap_bus), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .id_ready(w_id_ready), .ifid_valid(w_ifid_valid), .ifid_pc(w_ifid_pc), .ifid_ir(w_ifid_ir),
    .ifid_opcode(w_ifid_opcode), .ifid_bit_11(w_bit_11), .ifid_bit_5(w_bit_5), .ifid_bit_4(w_bit_4)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_pc = PC_RESET;
  bit          discard = 1'b0;
  logic [15:0] target = 16'h0000;
  int          lat = 1;
  int          wait_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      16'h0004: return 16'h9ABC;
      default:  return a * 16'h9E37 + 16'h1357;
    endcase
  endfunction

  // One clock: check state left by the last edge, drive inputs and cache, update the model.
  task automatic cycle(input bit rst, input bit rdy, input bit redir, input logic [15:0] rpc);
    exp_t        e;
    bit          resp;
    logic [15:0] rd;
    @(negedge clk);
    check("ifid_valid", ifid_valid, (sb_q.size() != 0));
    check("imem_read", imem_bus.imem_read, !reset && (discard || sb_q.size() < 2));
    check("imem_address", imem_bus.imem_address, exp_pc);
    reset       = rst;
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    resp = 1'b0;
    rd   = mem_word(imem_bus.imem_address);
    if (!rst && imem_bus.imem_read) begin
      resp = (wait_cnt >= lat - 1);
      if (resp) wait_cnt = 0;
      else      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    imem_bus.imem_resp  = resp;
    imem_bus.imem_rdata = resp ? rd : 16'hDEAD;
    if (rst) begin
      check("read_in_reset", imem_bus.imem_read, 1'b0);
      sb_q.delete();
      exp_pc  = PC_RESET;
      discard = 1'b0;
    end else begin
      if (ifid_valid && rdy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("ifid_pc", ifid_pc, e.pc);
          check("ifid_ir", ifid_ir, e.ir);
          check("ifid_opcode", ifid_opcode, e.ir[15:12]);
          check("ifid_bits", {ifid_bit_11, ifid_bit_5, ifid_bit_4}, {e.ir[11], e.ir[5], e.ir[4]});
        end
      end
      if (redir) begin
        sb_q.delete();
        if (imem_bus.imem_read && !resp) begin
          discard = 1'b1;
          target  = rpc;
        end else begin
          exp_pc  = rpc;
          discard = 1'b0;
        end
      end else if (resp) begin
        if (discard) begin
          exp_pc  = target;
          discard = 1'b0;
        end else begin
          e.pc = exp_pc + 16'd2;
          e.ir = rd;
          sb_q.push_back(e);
          exp_pc = exp_pc + 16'd2;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] rnd_pc;
    imem_bus.imem_resp  = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    wrap_bus.imem_resp  = 1'b1;
    wrap_bus.imem_rdata = 16'h5A5A;

    repeat (2) cycle(1, 0, 0, 16'h0000);
    check("rst_ifid_pc", ifid_pc, 16'h0000);
    check("rst_ifid_ir", ifid_ir, 16'h0000);

    // Streaming with a single-cycle cache
    cycle(0, 1, 0, 16'h0000);
    check("wrap_addr0", wrap_bus.imem_address, 16'hFFFE);
    cycle(0, 1, 0, 16'h0000);
    check("stream_ir0", ifid_ir, 16'h1234);
    check("stream_pc0", ifid_pc, 16'h0002);
    check("stream_op0", ifid_opcode, 4'h1);
    check("wrap_ifid_pc", w_ifid_pc, 16'h0000);
    check("wrap_addr1", wrap_bus.imem_address, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    check("stream_ir1", ifid_ir, 16'h5678);
    check("stream_pc1", ifid_pc, 16'h0004);
    cycle(0, 1, 0, 16'h0000);
    check("stream_ir2", ifid_ir, 16'h9ABC);
    check("stream_pc2", ifid_pc, 16'h0006);
    repeat (3) cycle(0, 1, 0, 16'h0000);

    // Backpressure
    repeat (4) cycle(0, 0, 0, 16'h0000);
    check("bp_read_drop", imem_bus.imem_read, 1'b0);
    repeat (6) cycle(0, 1, 0, 16'h0000);

    // Redirect while a 3-cycle read to 0x0010 is outstanding
    repeat (3) cycle(0, 0, 0, 16'h0000);
    lat = 3;
    cycle(0, 0, 1, 16'h0010);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 1, 1, 16'h3000);
    cycle(0, 1, 0, 16'h0000);
    check("disc_addr_hold", imem_bus.imem_address, 16'h0010);
    check("disc_resp", imem_bus.imem_resp, 1'b1);
    cycle(0, 1, 0, 16'h0000);
    check("disc_new_addr", imem_bus.imem_address, 16'h3000);
    check("disc_ifid_valid", ifid_valid, 1'b0);
    repeat (8) cycle(0, 1, 0, 16'h0000);

    // Redirect coincident with a response
    lat = 1;
    repeat (2) cycle(0, 1, 0, 16'h0000);
    cycle(0, 1, 1, 16'h3000);
    check("coinc_resp", imem_bus.imem_resp, 1'b1);
    cycle(0, 1, 0, 16'h0000);
    check("coinc_pc", imem_bus.imem_address, 16'h3000);
    check("coinc_valid", ifid_valid, 1'b0);
    repeat (3) cycle(0, 1, 0, 16'h0000);

    // Back-to-back redirects during a discard: last target wins
    lat = 3;
    cycle(0, 1, 1, 16'h0100);
    cycle(0, 1, 1, 16'h0200);
    repeat (8) cycle(0, 1, 0, 16'h0000);

    // Randomised traffic
    repeat (300) begin
      lat    = $urandom_range(1, 3);
      rnd_pc = 16'($urandom) & 16'hFFFE;
      cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rnd_pc);
    end

    // Reset with a full hold buffer, then reset during an outstanding read
    lat = 1;
    repeat (4) cycle(0, 0, 0, 16'h0000);
    check("full_read_low", imem_bus.imem_read, 1'b0);
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    check("rst_full_valid", ifid_valid, 1'b0);
    repeat (5) cycle(0, 1, 0, 16'h0000);
    lat = 3;
    cycle(0, 1, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    repeat (8) cycle(0, 1, 0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
